// File: rtl/frame_energy_meter.sv
// frame_energy_meter
// Drains one ping-pong buffer per ram_buffer_ready_i pulse and publishes the
// frame's sum of squares, mean square and saturated absolute peak with a
// one-cycle result_valid_o strobe. Two-stage datapath: stage 1 squares the
// sample and takes its magnitude, stage 2 accumulates and tracks the peak.
module frame_energy_meter #(
    parameter int SAMPLE_W  = 24,
    parameter int FRAME_LEN = 32,
    localparam int ENERGY_W = 2 * SAMPLE_W + $clog2(FRAME_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [SAMPLE_W-1:0]   ram_read_data_i,
    input  logic                  ram_read_valid_i,
    output logic                  ram_read_ready_o,
    input  logic                  ram_buffer_ready_i,
    output logic [ENERGY_W-1:0]   energy_o,
    output logic [2*SAMPLE_W-1:0] mean_sq_o,
    output logic [SAMPLE_W-2:0]   peak_o,
    output logic                  result_valid_o,
    output logic [15:0]           frame_count_o,
    output logic                  overrun_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int SQ_W  = 2 * SAMPLE_W;
    localparam int MAG_W = SAMPLE_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Control state
    state_e              state_q;
    logic                ready_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                overrun_q;

    // Stage 1 registers
    logic                s1_valid_q;
    logic                s1_last_q;
    logic [SQ_W-1:0]     s1_sq_q;
    logic [MAG_W-1:0]    s1_mag_q;

    // Stage 2 running state and published results
    logic [ENERGY_W-1:0] acc_q;
    logic [MAG_W-1:0]    peak_run_q;
    logic [ENERGY_W-1:0] energy_q;
    logic [SQ_W-1:0]     mean_sq_q;
    logic [MAG_W-1:0]    peak_q;
    logic                result_valid_q;
    logic [15:0]         frame_count_q;

    // Combinational helpers
    logic                handshake;
    logic                frame_start;
    logic                last_sample;
    logic [SQ_W-1:0]     sample_sq_d;
    logic [MAG_W-1:0]    sample_mag_d;
    logic [ENERGY_W-1:0] acc_sum_d;
    logic [MAG_W-1:0]    peak_next_d;

    assign handshake   = ram_read_valid_i && ready_q;
    assign frame_start = (state_q == ST_IDLE) && ram_buffer_ready_i;
    assign last_sample = (cnt_q == CNT_W'(FRAME_LEN - 1));

    // Square of the raw signed sample and its magnitude saturated to MAG_W bits
    always_comb begin
        logic signed [SAMPLE_W-1:0] sample_s;
        logic signed [SQ_W-1:0]     sample_ext;
        logic signed [SQ_W-1:0]     prod;
        logic        [SAMPLE_W-1:0] neg_val;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        sample_mag_d = '0;
        sample_s     = $signed(ram_read_data_i);
        sample_ext   = SQ_W'(sample_s);
        prod         = sample_ext * sample_ext;
        sample_sq_d  = $unsigned(prod);
        neg_val      = ~ram_read_data_i + SAMPLE_W'(1);
        if (!ram_read_data_i[SAMPLE_W-1]) begin
            sample_mag_d = ram_read_data_i[MAG_W-1:0];
        end else if (ram_read_data_i[MAG_W-1:0] == '0) begin
            // Most negative code has no positive twin; clamp to full scale.
            sample_mag_d = '1;
        end else begin
            sample_mag_d = neg_val[MAG_W-1:0];
        end
    end

    // Stage 2 arithmetic: next accumulator and next running peak
    always_comb begin
        acc_sum_d   = acc_q + ENERGY_W'(s1_sq_q);
        peak_next_d = (s1_mag_q > peak_run_q) ? s1_mag_q : peak_run_q;
    end

    // Frame FSM: IDLE waits for a buffer, READ takes FRAME_LEN samples, DRAIN
    // lets the pipeline finish; ready and overrun are registered here
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            case (state_q)
                ST_IDLE: begin
                    if (ram_buffer_ready_i) begin
                        state_q <= ST_READ;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_READ: begin
                    if (ram_buffer_ready_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (handshake) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_sample) begin
                            state_q <= ST_DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ram_buffer_ready_i) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture square, magnitude and last flag on each handshake
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sq_q    <= '0;
            s1_mag_q   <= '0;
        end else begin
            s1_valid_q <= handshake;
            if (handshake) begin
                s1_last_q <= last_sample;
                s1_sq_q   <= sample_sq_d;
                s1_mag_q  <= sample_mag_d;
            end
        end
    end

    // Stage 2: accumulate, track peak, publish results on the last sample
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q          <= '0;
            peak_run_q     <= '0;
            energy_q       <= '0;
            mean_sq_q      <= '0;
            peak_q         <= '0;
            result_valid_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (frame_start) begin
                acc_q      <= '0;
                peak_run_q <= '0;
            end else if (s1_valid_q) begin
                acc_q      <= acc_sum_d;
                peak_run_q <= peak_next_d;
                if (s1_last_q) begin
                    energy_q       <= acc_sum_d;
                    mean_sq_q      <= acc_sum_d[ENERGY_W-1:CNT_W];
                    peak_q         <= peak_next_d;
                    result_valid_q <= 1'b1;
                    frame_count_q  <= frame_count_q + 16'd1;
                end
            end
        end
    end

    assign ram_read_ready_o = ready_q;
    assign energy_o         = energy_q;
    assign mean_sq_o        = mean_sq_q;
    assign peak_o           = peak_q;
    assign result_valid_o   = result_valid_q;
    assign frame_count_o    = frame_count_q;
    assign overrun_o        = overrun_q;

endmodule

// File: doc/frame_energy_meter.md
Name: frame_energy_meter

Overview:
- Consumer stage that drains one ping-pong buffer from ram_logic per buffer_ready pulse.
- Computes per-frame sum of squares, mean square and absolute peak over the FRAME_LEN buffered 24-bit samples.
- Publishes the results with a one-cycle valid strobe for downstream level/AGC logic. It runs alongside, or instead of, the VU meter on the RAM read port.

Parameters:
- SAMPLE_W, 24, signed sample width taken from ram_read_data_i[SAMPLE_W-1:0].
- FRAME_LEN, 32, samples per frame. Must equal the ram_logic DEPTH and be a power of two, at least 2.
- ENERGY_W, 2*SAMPLE_W+$clog2(FRAME_LEN) (53), accumulator and energy_o width. This is a derived localparam.

Ports:
- clk_i  in  1  system clock (27 MHz).
- rst_ni  in  1  reset, synchronous, active-low.
- ram_read_data_i  in  SAMPLE_W  signed two's-complement sample from the RAM read port.
- ram_read_valid_i  in  1  RAM read data valid.
- ram_read_ready_o  out  1  consumer ready. A sample transfers in any cycle where valid and ready are both 1.
- ram_buffer_ready_i  in  1  one-cycle pulse: a full buffer is available to drain.
- energy_o  out  ENERGY_W  unsigned sum of squares of the last completed frame.
- mean_sq_o  out  2*SAMPLE_W  energy_o >> $clog2(FRAME_LEN).
- peak_o  out  SAMPLE_W-1  maximum |sample| in the last completed frame.
- result_valid_o  out  1  one-cycle strobe: energy_o, mean_sq_o and peak_o were updated.
- frame_count_o  out  16  number of completed frames. Wraps 0xFFFF to 0.
- overrun_o  out  1  sticky flag: a buffer_ready pulse arrived while busy.

Behaviour:
- Clock is clk_i. Reset is synchronous, active-low (rst_ni sampled on the clk_i rising edge).
- Reset values:
  - FSM goes to IDLE.
  - ram_read_ready_o=0, result_valid_o=0, overrun_o=0.
  - energy_o, mean_sq_o, peak_o and frame_count_o all 0.
  - Sample counter, accumulator, running peak and pipeline registers cleared.
- Reset asserted mid-frame abandons the frame: no result strobe, frame_count_o is not incremented, and the next frame starts only on a new buffer_ready pulse.
- FSM states:
  - IDLE: ready=0. ram_buffer_ready_i=1 moves to READ next cycle, with sample counter, accumulator and running peak cleared.
  - READ: ready=1. Each handshake increments the sample counter. The handshake with counter==FRAME_LEN-1 moves to DRAIN. While valid=0, the FSM waits indefinitely; there is no timeout.
  - DRAIN: ready=0 for exactly one cycle, then IDLE.
- Pipeline:
  - Stage 1 (handshake edge) registers the square of the signed sample (2*SAMPLE_W bits, unsigned result), |sample| and a last flag.
  - Stage 2 adds the square into the accumulator and updates the running peak.
  - When stage 2 processes the last sample, energy_o, mean_sq_o and peak_o load the final values, result_valid_o is set for one cycle, and frame_count_o increments.
- Latency: final handshake in cycle N, then DRAIN in cycle N+1, then result_valid_o=1 in cycle N+2 (the first IDLE cycle).
- Arithmetic:
  - |-2^(SAMPLE_W-1)| saturates to 2^(SAMPLE_W-1)-1 for peak_o.
  - The square uses the raw value: (-2^23)^2 = 2^46.
  - The accumulator cannot overflow at ENERGY_W.
- Outputs hold their values between strobes.
- A ram_buffer_ready_i pulse in READ or DRAIN is ignored for draining and sets overrun_o. overrun_o is cleared only by reset.
- A pulse coinciding with the result_valid_o cycle is accepted, because the FSM is in IDLE then.
- ram_read_data_i is ignored whenever no handshake occurs.

Test Plan:
- Reset then 32 samples of 0x000100, valid held high → ready stays high for exactly 32 cycles; result_valid_o fires 2 cycles after the last handshake; energy_o=2097152, mean_sq_o=65536, peak_o=256, frame_count_o=1.
- Frame of 31 zeros plus one sample 0x800000 → energy_o=2^46, mean_sq_o=2^41, peak_o=0x7FFFFF.
- Frame alternating +1000/-1000 with valid dropped for 3 cycles every 4 samples → no samples lost or duplicated; energy_o=32000000, peak_o=1000.
- ram_buffer_ready_i pulsed in the middle of READ → overrun_o=1 and stays 1; the current frame's result is unchanged; no extra frame starts.
- rst_ni low for 1 cycle after 10 handshakes → all outputs 0; a following full frame of 0x000010 gives energy_o=8192, frame_count_o=1.
- Back-to-back: buffer_ready pulsed in the result_valid_o cycle → accepted; the second frame completes; frame_count_o=2; overrun_o=0.
